// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host-to-CPU program loader with start/watchdog/halt sequencing
// Optional word checksum gate: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int          ADDR_W         = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_RUN_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              program_load,
  output logic [31:0]       instruction,
  output logic [31:0]       load_addr,
  output logic              start,
  output logic              halt,
  input  logic              halt_req,
  output logic              busy,
  output logic              done,
  output logic              timeout
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  input  logic [31:0]       exp_sum,
  output logic              sum_err
`endif
);

  localparam int RUN_W = $clog2(MAX_RUN_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_HALT} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx_q;
  logic              flush_q;
  logic              hold_halt_q;
  logic [RUN_W-1:0]  run_cnt;
  logic              xfer;
  logic              last_xfer;
  logic              accept;
  logic              sum_ok;

  // flush_q marks the cycle after the final word, where its program_load is presented
  assign xfer      = (state == S_LOAD) && !flush_q && in_valid;
  assign last_xfer = xfer && (idx_q == len_q - ADDR_W'(1));
  assign accept    = load_req && (load_len != '0) && ((state == S_IDLE) || (state == S_HALT));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    start      = 1'b0;
    halt       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) next_state = S_LOAD;
      end
      S_LOAD: begin
        in_ready = !flush_q;
        busy     = 1'b1;
        halt     = hold_halt_q;
        if (flush_q) next_state = sum_ok ? S_START : S_HALT;
      end
      S_START: begin
        start      = 1'b1;
        busy       = 1'b1;
        next_state = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (halt_req || (run_cnt == RUN_LAST)) next_state = S_HALT;
      end
      S_HALT: begin
        halt = 1'b1;
        done = 1'b1;
        if (accept) next_state = S_LOAD;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q        <= '0;
      idx_q        <= '0;
      flush_q      <= 1'b0;
      hold_halt_q  <= 1'b0;
      run_cnt      <= '0;
      timeout      <= 1'b0;
      program_load <= 1'b0;
      instruction  <= '0;
      load_addr    <= '0;
    end else begin
      program_load <= xfer;
      if (xfer) begin
        instruction <= in_data;
        load_addr   <= BASE_ADDR + {{(32-ADDR_W-2){1'b0}}, idx_q, 2'b00};
        idx_q       <= idx_q + ADDR_W'(1);
        if (last_xfer) flush_q <= 1'b1;
      end
      if (accept) begin
        len_q       <= load_len;
        idx_q       <= '0;
        flush_q     <= 1'b0;
        timeout     <= 1'b0;
        run_cnt     <= '0;
        hold_halt_q <= (state == S_HALT);
      end
      // run_cnt is 0 in the START cycle, so the watchdog counts from the start pulse
      if (((state == S_START) || (state == S_RUN)) && (run_cnt != RUN_LAST))
        run_cnt <= run_cnt + RUN_W'(1);
      if ((state == S_RUN) && !halt_req && (run_cnt == RUN_LAST))
        timeout <= 1'b1;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  logic [31:0] exp_q;

  assign sum_ok = (sum_q == exp_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      exp_q   <= '0;
      sum_err <= 1'b0;
    end else begin
      if (xfer) sum_q <= sum_q + in_data;
      if ((state == S_LOAD) && flush_q && !sum_ok) sum_err <= 1'b1;
      if (accept) begin
        sum_q   <= '0;
        exp_q   <= exp_sum;
        sum_err <= 1'b0;
      end
    end
  end
`else
  assign sum_ok = 1'b1;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader
module tb_prog_loader;
  localparam int          ADDR_W = 4;
  localparam logic [31:0] BASE   = 32'hFFFF_FFF8;
  localparam int          MAXRUN = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_req;
  logic [ADDR_W-1:0] load_len;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              program_load;
  logic [31:0]       instruction;
  logic [31:0]       load_addr;
  logic              start;
  logic              halt;
  logic              halt_req;
  logic              busy;
  logic              done;
  logic              timeout;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]       exp_sum;
  logic              sum_err;
`endif

  prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_RUN_CYCLES(MAXRUN)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .program_load(program_load), .instruction(instruction), .load_addr(load_addr),
    .start(start), .halt(halt), .halt_req(halt_req), .busy(busy), .done(done),
    .timeout(timeout)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .exp_sum(exp_sum), .sum_err(sum_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic done_q = 1'b0;

  int          exp_pl_cyc[$];
  logic [31:0] exp_pl_addr[$];
  logic [31:0] exp_pl_data[$];
  int          exp_start[$];
  int          exp_halt_cyc[$];
  logic [31:0] exp_halt_to[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents an event
  always @(negedge clk) begin
    if (program_load) begin
      check("pl_expected", 32'(exp_pl_cyc.size() != 0), 32'd1);
      if (exp_pl_cyc.size() != 0) begin
        check("pl_cycle", cyc, exp_pl_cyc.pop_front());
        check("pl_addr", load_addr, exp_pl_addr.pop_front());
        check("pl_data", instruction, exp_pl_data.pop_front());
      end
    end
    if (start) begin
      check("start_expected", 32'(exp_start.size() != 0), 32'd1);
      if (exp_start.size() != 0) check("start_cycle", cyc, exp_start.pop_front());
      check("start_no_pl", program_load, 0);
      check("start_halt_low", halt, 0);
      check("start_busy", busy, 1);
    end
    if (done && !done_q) begin
      check("halt_expected", 32'(exp_halt_cyc.size() != 0), 32'd1);
      if (exp_halt_cyc.size() != 0) begin
        check("halt_cycle", cyc, exp_halt_cyc.pop_front());
        check("halt_timeout", timeout, exp_halt_to.pop_front());
      end
      check("halt_level", halt, 1);
    end
    done_q <= done;
  end

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_pl"}, program_load, 0);
    check({tag, "_instr"}, instruction, 0);
    check({tag, "_addr"}, load_addr, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_halt"}, halt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // halt_k = 0: let the watchdog expire; otherwise raise halt_req k cycles after start
  task automatic do_program(input logic [31:0] words[$], input bit bubbles,
                            input int halt_k, input bit from_halt);
    int last;
    int s;
    int g;
    logic [31:0] sum;
    sum = 0;
    foreach (words[i]) sum += words[i];
    load_req = 1'b1;
    load_len = ADDR_W'(words.size());
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_sum = sum;
`endif
    tick();
    load_req = 1'b0;
    load_len = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
    check("load_sum_err_clr", sum_err, 0);
`endif
    for (int i = 0; i < words.size(); i++) begin
      if (bubbles) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          check("bubble_ready", in_ready, 1);
          if (from_halt) check("bubble_halt_held", halt, 1);
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = words[i];
      exp_pl_cyc.push_back(cyc + 1);
      exp_pl_addr.push_back(BASE + 32'(i) * 32'd4);
      exp_pl_data.push_back(words[i]);
      check("load_ready", in_ready, 1);
      check("load_busy", busy, 1);
      check("load_timeout_clr", timeout, 0);
      if (from_halt) check("load_halt_held", halt, 1);
      tick();
    end
    in_valid = 1'b0;
    last = cyc - 1;
    check("ready_drop", in_ready, 0);
    if (from_halt) check("flush_halt_held", halt, 1);
    s = last + 2;
    exp_start.push_back(s);
    tick();
    if (halt_k == 0) begin
      exp_halt_cyc.push_back(s + MAXRUN);
      exp_halt_to.push_back(1);
      repeat (MAXRUN) tick();
    end else begin
      repeat (halt_k) tick();
      halt_req = 1'b1;
      exp_halt_cyc.push_back(s + halt_k + 1);
      exp_halt_to.push_back(0);
      tick();
      halt_req = 1'b0;
    end
    tick();
  endtask

  logic [31:0] words[$];
  int n;
  int k;
  int last_c;

  initial begin
    #2000000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; load_req = 1'b0; load_len = '0; in_valid = 1'b0;
    in_data = '0; halt_req = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_sum = '0;
`endif
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b0;
    tick();

    load_req = 1'b1; load_len = '0;
    tick();
    load_req = 1'b0;
    tick();
    check("idle_len0_busy", busy, 0);
    check("idle_len0_ready", in_ready, 0);

    words = '{32'h20010005, 32'h20020007, 32'h00221820};
    do_program(words, 1'b0, 0, 1'b0);

    load_req = 1'b1; load_len = '0;
    tick();
    load_req = 1'b0;
    tick();
    check("halt_len0_done", done, 1);
    check("halt_len0_busy", busy, 0);

    words = '{$urandom, $urandom};
    do_program(words, 1'b0, 5, 1'b1);

    words = '{$urandom, $urandom, $urandom};
    do_program(words, 1'b1, MAXRUN - 1, 1'b1);

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 6);
      words.delete();
      for (int j = 0; j < n; j++) words.push_back($urandom);
      k = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, MAXRUN - 1);
      do_program(words, 1'b1, k, 1'b1);
    end

    load_req = 1'b1; load_len = ADDR_W'(5);
    tick();
    load_req = 1'b0; load_len = '0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      exp_pl_cyc.push_back(cyc + 1);
      exp_pl_addr.push_back(BASE + 32'(i) * 32'd4);
      exp_pl_data.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_idle("midload_reset");
    reset = 1'b0;
    words = '{$urandom};
    do_program(words, 1'b0, 3, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    load_req = 1'b1; load_len = ADDR_W'(2); exp_sum = 32'd4;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i + 1);
      exp_pl_cyc.push_back(cyc + 1);
      exp_pl_addr.push_back(BASE + 32'(i) * 32'd4);
      exp_pl_data.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    last_c = cyc - 1;
    exp_halt_cyc.push_back(last_c + 2);
    exp_halt_to.push_back(0);
    tick();
    tick();
    check("sum_err_set", sum_err, 1);
    check("sum_err_done", done, 1);
    tick();
    words = '{32'd1, 32'd2};
    do_program(words, 1'b0, 4, 1'b1);
    check("sum_ok_no_err", sum_err, 0);
`else
    last_c = 0;
`endif

    repeat (4) tick();
    check("pl_queue_drained", exp_pl_cyc.size(), 0);
    check("start_queue_drained", exp_start.size(), 0);
    check("halt_queue_drained", exp_halt_cyc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Sequencer upstream of the CPU top level. Accepts a stream of 32-bit instruction words from a host over a valid/ready handshake and drives the CPU `program_load`/`instruction` interface to fill instruction memory. It then pulses `start`, supervises the run with a cycle watchdog and drives `halt`. It is the only driver of the CPU's `start`, `program_load`, `halt` and `instruction` inputs.

Parameters:
- ADDR_W, 10, width of the word counter and of `load_len`; max program length is 2^ADDR_W-1 words.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_RUN_CYCLES, 100000, watchdog limit in cycles counted from the `start` pulse.

Ports:
- clk  in  1  global clock
- reset  in  1  synchronous, active-high reset
- load_req  in  1  request to begin loading; sampled only in IDLE or HALT
- load_len  in  ADDR_W  number of words to load; latched together with `load_req`
- in_valid  in  1  host word valid
- in_data  in  32  host instruction word
- in_ready  out  1  loader can accept a word
- program_load  out  1  to CPU program_load; high for exactly one cycle per word
- instruction  out  32  to CPU instruction port
- load_addr  out  32  byte address of the word currently presented
- start  out  1  to CPU start; one-cycle pulse
- halt  out  1  to CPU halt
- halt_req  in  1  host stop request
- busy  out  1  high in LOAD, START and RUN
- done  out  1  high in HALT
- timeout  out  1  set when the watchdog caused the halt; cleared on the next `load_req`

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE. All outputs are 0 and all counters are 0. Reset asserted in any state, including mid-LOAD or RUN, aborts the operation in the same cycle.
- States: IDLE, LOAD, START, RUN, HALT.
- IDLE:
  - `load_req` with `load_len`!=0 → latch the length, clear the word index, go to LOAD.
  - `load_req` with `load_len`==0 → ignored; stay in IDLE.
- LOAD:
  - `in_ready` is 1 for the whole state.
  - A transfer is a cycle with `in_valid`&`in_ready`.
  - A transfer in cycle t produces, registered in cycle t+1: `program_load`=1, `instruction`=`in_data`, `load_addr`=BASE_ADDR+4*index.
  - Outputs hold their values when there is no transfer, but `program_load` returns to 0.
  - The index increments per transfer. The transfer at index `load_len`-1 moves the state to START, and `in_ready` drops in that next cycle.
  - Host bubbles (`in_valid`=0) are allowed with no timeout.
  - `load_req`/`halt_req` are ignored in this state.
- START: `start`=1 for exactly one cycle. `program_load` is guaranteed 0 in this cycle. Next state is RUN.
- RUN:
  - The run counter starts at 0 and increments each cycle.
  - If `halt_req`=1, or the counter reaches MAX_RUN_CYCLES-1, go to HALT.
  - If both conditions occur in the same cycle, `halt_req` takes priority and `timeout` stays 0.
  - The counter saturates and never wraps.
- HALT:
  - `halt`=1 and `done`=1, held.
  - `load_req` with nonzero length → go to LOAD with `halt` held at 1 during LOAD, so the CPU stays stopped while memory is rewritten.
  - `halt` deasserts in the START cycle of the new run.
- Address arithmetic is 32-bit modulo 2^32. `load_addr` wraps silently if BASE_ADDR+4*index overflows.
- Latency: the first `start` is asserted exactly 2 cycles after the final transfer (one registered-output cycle, then START).

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Ports added when defined: input `exp_sum` [31:0], latched with `load_req`; output `sum_err`.
- During LOAD, a 32-bit wraparound sum of all accepted words accumulates. It is cleared on `load_req`.
- After the last transfer:
  - Sum == `exp_sum` → go to START as normal.
  - Mismatch → go directly to HALT with `sum_err`=1 and no `start` pulse. `sum_err` clears on the next `load_req`.
- When undefined: no extra ports, and LOAD always proceeds to START.

Test Plan:
- Normal load: `load_req`, `load_len`=3, words 0x20010005, 0x20020007, 0x00221820 with back-to-back valid → `program_load` pulses on 3 consecutive cycles at `load_addr` 0x0, 0x4, 0x8; `start` pulses 2 cycles after the last transfer; `busy`=1 throughout.
- Bubbles: the same 3 words with `in_valid` gapped 1-0-0-1-1 → exactly 3 `program_load` pulses with correct addresses; no pulse during the gaps.
- Watchdog: MAX_RUN_CYCLES=16 with no `halt_req` → `halt`=1, `done`=1, `timeout`=1 exactly 16 cycles after the `start` pulse; a simultaneous `halt_req` on cycle 16 gives `timeout`=0.
- Reset mid-load: assert `reset` after 2 of 5 words → the next cycle shows IDLE with all outputs 0; a new `load_req` with `load_len`=1 restarts at `load_addr`=BASE_ADDR.
- Reload from HALT: `halt_req` during RUN, then `load_req` with `load_len`=2 → `halt` stays 1 through LOAD, drops in the `start` cycle; `load_len`=0 in IDLE produces no state change.
- (With PROG_LOADER_CHECKSUM_EN) words 1, 2 with `exp_sum`=4 → HALT, `sum_err`=1, no `start`; with `exp_sum`=3 → normal `start`.
